// File: rtl/fetch_ctrl_if.sv
// Fetch-control bundle: pipeline hazard inputs in, PC/pipeline-register controls and status out.
// The controller connects through the slave modport; the pipeline/back end uses master.
interface fetch_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             start;
    logic             ext_stall;
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic             ex_valid;
    logic             ex_is_load;
    logic [4:0]       ex_rd;
    logic             ex_redirect;
    logic [XLEN-1:0]  ex_target;
    logic             wb_halt;

    logic             pc_stall;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             if_flush;
    logic             id_hold;
    logic             ex_bubble;
    logic             halted;
    logic             fault;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output start, ext_stall, id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               ex_valid, ex_is_load, ex_rd, ex_redirect, ex_target, wb_halt,
        input  pc_stall, redirect_valid, redirect_pc, if_flush, id_hold, ex_bubble,
               halted, fault, cycle_cnt, stall_cnt
    );

    modport slave (
        input  start, ext_stall, id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               ex_valid, ex_is_load, ex_rd, ex_redirect, ex_target, wb_halt,
        output pc_stall, redirect_valid, redirect_pc, if_flush, id_hold, ex_bubble,
               halted, fault, cycle_cnt, stall_cnt
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencing and hazard control: IDLE/START/RUN/HALT, load-use stall, EX redirect, misaligned fault.
// Controls are combinational (0 cycles); ext_stall freezes PC and IF/ID with no bubble until it drops.
module fetch_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.slave  ctl
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_n;
    logic             halted_q;
    logic             fault_q;
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] stall_q;
    logic             fault_set;
    logic             stall_inc;
    logic             load_use;

    // x0 is hardwired zero, so a load targeting it can never create a dependency.
    assign load_use = ctl.id_valid && ctl.ex_valid && ctl.ex_is_load && (ctl.ex_rd != 5'd0) &&
                      ((ctl.id_uses_rs1 && (ctl.id_rs1 == ctl.ex_rd)) ||
                       (ctl.id_uses_rs2 && (ctl.id_rs2 == ctl.ex_rd)));

    always_comb begin
        state_n            = state;
        fault_set          = 1'b0;
        stall_inc          = 1'b0;
        ctl.pc_stall       = 1'b0;
        ctl.redirect_valid = 1'b0;
        ctl.redirect_pc    = '0;
        ctl.if_flush       = 1'b0;
        ctl.id_hold        = 1'b0;
        ctl.ex_bubble      = 1'b0;
        case (state)
            IDLE: begin
                ctl.pc_stall  = 1'b1;
                ctl.if_flush  = 1'b1;
                ctl.ex_bubble = 1'b1;
                if (ctl.start) state_n = START;
            end
            START: begin
                ctl.redirect_valid = 1'b1;
                ctl.redirect_pc    = RESET_PC;
                ctl.if_flush       = 1'b1;
                ctl.ex_bubble      = 1'b1;
                state_n            = RUN;
            end
            RUN: begin
                if (ctl.ext_stall) begin
                    // EX is frozen too, so any pending redirect is simply re-presented later.
                    ctl.pc_stall = 1'b1;
                    ctl.id_hold  = 1'b1;
                    stall_inc    = 1'b1;
                end else if (ctl.wb_halt) begin
                    ctl.pc_stall  = 1'b1;
                    ctl.if_flush  = 1'b1;
                    ctl.ex_bubble = 1'b1;
                    state_n       = HALT;
                end else if (ctl.ex_valid && ctl.ex_redirect) begin
                    ctl.if_flush  = 1'b1;
                    ctl.ex_bubble = 1'b1;
                    if (ctl.ex_target[1:0] != 2'b00) begin
                        ctl.pc_stall = 1'b1;
                        fault_set    = 1'b1;
                        state_n      = HALT;
                    end else begin
                        ctl.redirect_valid = 1'b1;
                        ctl.redirect_pc    = ctl.ex_target;
                    end
                end else if (load_use) begin
                    ctl.pc_stall  = 1'b1;
                    ctl.id_hold   = 1'b1;
                    ctl.ex_bubble = 1'b1;
                    stall_inc     = 1'b1;
                end
            end
            HALT: begin
                ctl.pc_stall  = 1'b1;
                ctl.if_flush  = 1'b1;
                ctl.ex_bubble = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
            cycle_q  <= '0;
            stall_q  <= '0;
        end else begin
            state    <= state_n;
            halted_q <= (state_n == HALT);
            if (fault_set) fault_q <= 1'b1;
            if ((state == START) || (state == RUN)) cycle_q <= cycle_q + 1'b1;
            if (stall_inc) stall_q <= stall_q + 1'b1;
        end
    end

    assign ctl.halted    = halted_q;
    assign ctl.fault     = fault_q;
    assign ctl.cycle_cnt = cycle_q;
    assign ctl.stall_cnt = stall_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: start sequence, load-use, redirect, ext_stall, fault and halt.
module tb_fetch_ctrl;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_ctrl_if #(.XLEN(32), .CNT_W(32)) ctl();

    fetch_ctrl #(.XLEN(32), .RESET_PC(RST_PC), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .ctl (ctl.slave)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_cyc   = '0;
    logic [31:0] exp_stall = '0;

    // {pc_stall, id_hold, if_flush, ex_bubble, redirect_valid}
    wire [4:0] ctrl = {ctl.pc_stall, ctl.id_hold, ctl.if_flush, ctl.ex_bubble, ctl.redirect_valid};

    task automatic clear_inputs();
        ctl.start = 0; ctl.ext_stall = 0; ctl.id_valid = 0; ctl.id_rs1 = 0; ctl.id_rs2 = 0;
        ctl.id_uses_rs1 = 0; ctl.id_uses_rs2 = 0; ctl.ex_valid = 0; ctl.ex_is_load = 0;
        ctl.ex_rd = 0; ctl.ex_redirect = 0; ctl.ex_target = 0; ctl.wb_halt = 0;
    endtask

    task automatic tick(input bit counted);
        if (counted) exp_cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1; clear_inputs();
        tick(0); tick(0);
        #1;
        total++; if (ctrl !== 5'b10110) begin bad++; $display("FAIL reset_ctrl got=%b exp=10110", ctrl); end
        total++; if (ctl.halted !== 1'b0 || ctl.fault !== 1'b0) begin bad++; $display("FAIL reset_flags halted=%b fault=%b exp=0/0", ctl.halted, ctl.fault); end
        total++; if (ctl.cycle_cnt !== 32'd0 || ctl.stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt cyc=%0d stall=%0d exp=0/0", ctl.cycle_cnt, ctl.stall_cnt); end
        total++; if (ctl.redirect_pc !== 32'd0) begin bad++; $display("FAIL reset_rpc got=%h exp=0", ctl.redirect_pc); end
        rst = 0;
        exp_cyc = 0; exp_stall = 0;
    endtask

    task automatic test_start();
        tick(0);
        ctl.start = 1; #1;
        total++; if (ctrl !== 5'b10110) begin bad++; $display("FAIL idle_ctrl got=%b exp=10110", ctrl); end
        tick(0); #1;
        total++; if (ctrl !== 5'b00111) begin bad++; $display("FAIL start_ctrl got=%b exp=00111", ctrl); end
        total++; if (ctl.redirect_pc !== RST_PC) begin bad++; $display("FAIL start_rpc got=%h exp=%h", ctl.redirect_pc, RST_PC); end
        total++; if (ctl.cycle_cnt !== 32'd0) begin bad++; $display("FAIL start_cyc got=%0d exp=0", ctl.cycle_cnt); end
        tick(1); #1;
        total++; if (ctrl !== 5'b00000) begin bad++; $display("FAIL run_ctrl got=%b exp=00000", ctrl); end
        total++; if (ctl.cycle_cnt !== 32'd1) begin bad++; $display("FAIL run_cyc got=%0d exp=1", ctl.cycle_cnt); end
        ctl.start = 0;
        tick(1);
    endtask

    task automatic test_load_use();
        // {id_valid, rs1, rs2, uses_rs1, uses_rs2, ex_rd, ex_is_load, expected hazard}
        logic [20:0] vec [6] = '{
            {1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1},
            {1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0},
            {1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1},
            {1'b1, 5'd7, 5'd7, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0},
            {1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0},
            {1'b0, 5'd9, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0}
        };
        for (int i = 0; i < 6; i++) begin
            ctl.ex_valid = 1;
            {ctl.id_valid, ctl.id_rs1, ctl.id_rs2, ctl.id_uses_rs1, ctl.id_uses_rs2, ctl.ex_rd, ctl.ex_is_load} = vec[i][20:1];
            #1;
            total++; if (ctrl !== (vec[i][0] ? 5'b11010 : 5'b00000)) begin bad++; $display("FAIL loaduse_ctrl[%0d] got=%b exp=%b", i, ctrl, vec[i][0] ? 5'b11010 : 5'b00000); end
            total++; if (ctl.stall_cnt !== exp_stall) begin bad++; $display("FAIL loaduse_stall[%0d] got=%0d exp=%0d", i, ctl.stall_cnt, exp_stall); end
            if (vec[i][0]) exp_stall++;
            tick(1);
        end
        clear_inputs(); #1;
        total++; if (ctrl !== 5'b00000) begin bad++; $display("FAIL loaduse_clear got=%b exp=00000", ctrl); end
        total++; if (ctl.stall_cnt !== exp_stall) begin bad++; $display("FAIL loaduse_stall_end got=%0d exp=%0d", ctl.stall_cnt, exp_stall); end
        tick(1);
    endtask

    task automatic test_redirect();
        ctl.id_valid = 1; ctl.ex_valid = 1; ctl.ex_is_load = 1; ctl.ex_rd = 5; ctl.id_rs2 = 5;
        ctl.id_uses_rs2 = 1; ctl.ex_redirect = 1; ctl.ex_target = 32'h40;
        #1;
        total++; if (ctrl !== 5'b00111) begin bad++; $display("FAIL redir_ctrl got=%b exp=00111", ctrl); end
        total++; if (ctl.redirect_pc !== 32'h40) begin bad++; $display("FAIL redir_pc got=%h exp=00000040", ctl.redirect_pc); end
        tick(1);
        ctl.ex_valid = 0; #1;
        total++; if (ctrl !== 5'b00000 || ctl.redirect_pc !== 32'd0) begin bad++; $display("FAIL redir_exinvalid ctrl=%b pc=%h exp=00000/0", ctrl, ctl.redirect_pc); end
        total++; if (ctl.stall_cnt !== exp_stall) begin bad++; $display("FAIL redir_stall got=%0d exp=%0d", ctl.stall_cnt, exp_stall); end
        tick(1);
        clear_inputs();
    endtask

    task automatic test_ext_stall();
        ctl.ext_stall = 1; ctl.ex_valid = 1; ctl.ex_redirect = 1; ctl.ex_target = 32'h80;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (ctrl !== 5'b11000 || ctl.redirect_pc !== 32'd0) begin bad++; $display("FAIL xstall_ctrl[%0d] ctrl=%b pc=%h exp=11000/0", i, ctrl, ctl.redirect_pc); end
            total++; if (ctl.stall_cnt !== exp_stall) begin bad++; $display("FAIL xstall_cnt[%0d] got=%0d exp=%0d", i, ctl.stall_cnt, exp_stall); end
            exp_stall++;
            tick(1);
        end
        ctl.ext_stall = 0; #1;
        total++; if (ctrl !== 5'b00111 || ctl.redirect_pc !== 32'h80) begin bad++; $display("FAIL xstall_redir ctrl=%b pc=%h exp=00111/80", ctrl, ctl.redirect_pc); end
        total++; if (ctl.stall_cnt !== exp_stall) begin bad++; $display("FAIL xstall_total got=%0d exp=%0d", ctl.stall_cnt, exp_stall); end
        tick(1);
        clear_inputs();
    endtask

    task automatic check_halt(input logic exp_fault, input string tag);
        for (int i = 0; i < 3; i++) begin
            ctl.start = i[0]; ctl.ext_stall = 1; ctl.ex_valid = 1; ctl.ex_redirect = 1; ctl.ex_target = 32'h40;
            #1;
            total++; if (ctrl !== 5'b10110) begin bad++; $display("FAIL %s_ctrl[%0d] got=%b exp=10110", tag, i, ctrl); end
            total++; if (ctl.halted !== 1'b1 || ctl.fault !== exp_fault) begin bad++; $display("FAIL %s_flags[%0d] halted=%b fault=%b exp=1/%b", tag, i, ctl.halted, ctl.fault, exp_fault); end
            total++; if (ctl.cycle_cnt !== exp_cyc || ctl.stall_cnt !== exp_stall) begin bad++; $display("FAIL %s_cnt[%0d] cyc=%0d stall=%0d exp=%0d/%0d", tag, i, ctl.cycle_cnt, ctl.stall_cnt, exp_cyc, exp_stall); end
            tick(0);
        end
        clear_inputs();
    endtask

    task automatic test_fault();
        ctl.ex_valid = 1; ctl.ex_redirect = 1; ctl.ex_target = 32'h42;
        #1;
        total++; if (ctrl[3:0] !== 4'b0110) begin bad++; $display("FAIL fault_ctrl got=%b exp=x0110", ctrl); end
        total++; if (ctl.halted !== 1'b0) begin bad++; $display("FAIL fault_early_halt got=%b exp=0", ctl.halted); end
        tick(1);
        clear_inputs();
        check_halt(1'b1, "fault_halt");
    endtask

    task automatic test_reset_out();
        rst = 1; ctl.start = 1;
        tick(0);
        rst = 0; ctl.start = 0; exp_cyc = 0; exp_stall = 0;
        #1;
        total++; if (ctrl !== 5'b10110 || ctl.halted !== 1'b0 || ctl.fault !== 1'b0) begin bad++; $display("FAIL rst_out ctrl=%b halted=%b fault=%b exp=10110/0/0", ctrl, ctl.halted, ctl.fault); end
        total++; if (ctl.cycle_cnt !== 32'd0 || ctl.stall_cnt !== 32'd0) begin bad++; $display("FAIL rst_out_cnt cyc=%0d stall=%0d exp=0/0", ctl.cycle_cnt, ctl.stall_cnt); end
    endtask

    task automatic test_wb_halt();
        ctl.start = 1;
        tick(0);
        ctl.start = 0;
        tick(1);
        ctl.wb_halt = 1; ctl.ex_valid = 1; ctl.ex_redirect = 1; ctl.ex_target = 32'h40;
        #1;
        total++; if (ctrl !== 5'b10110) begin bad++; $display("FAIL wbhalt_ctrl got=%b exp=10110", ctrl); end
        tick(1);
        clear_inputs();
        check_halt(1'b0, "wb_halt");
    endtask

    initial begin
        test_reset();
        test_start();
        test_load_use();
        test_redirect();
        test_ext_stall();
        test_fault();
        test_reset_out();
        test_wb_halt();
        test_reset_out();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
